noise_cdf_injector: RTL and testbench

Parametrised multi-channel additive-noise injector for the SERDES channel model. On a load request it bursts a noise inverse-CDF lookup table out of on-chip memory (packed MEM_W-bit words) into an internal table. Once loaded, each channel adds table[LFSR index] to its incoming sample with saturation. It sits between the channel/ISI stage and the receiver/equaliser, and generalises the single-channel 8-bit 128-entry noise wrapper to N channels, configurable widths and depth, memory latency and saturating arithmetic.

---
 rtl/noise_cdf_injector.sv | 151 +++++++++++++++
 tb/tb_noise_cdf_injector.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_cdf_injector.sv
// Multi-channel additive-noise injector: bursts an inverse-CDF table in from memory,
// then adds table[LFSR] to each channel's sample with saturation.
module noise_cdf_injector #(
  parameter int          DATA_W      = 8,
  parameter int          ENTRY_W     = 8,
  parameter int          MEM_W       = 64,
  parameter int          TABLE_DEPTH = 256,
  parameter int          NUM_CH      = 2,
  parameter int          ADDR_W      = 14,
  parameter int          BASE_ADDR   = 0,
  parameter int          RD_LAT      = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       load_mem,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_rd,
  input  logic [MEM_W-1:0]           mem_rdata,
  output logic                       done_wait,
  input  logic [NUM_CH*DATA_W-1:0]   noise_in,
  input  logic                       noise_in_valid,
  output logic [NUM_CH*DATA_W-1:0]   noise_out,
  output logic                       noise_out_valid
);

  localparam int LANES = MEM_W / ENTRY_W;
  localparam int WORDS = TABLE_DEPTH / LANES;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam int IDX_W = $clog2(TABLE_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic   [CNT_W-1:0]         issue_cnt;
  logic   [CNT_W-1:0]         ret_cnt;
  logic   [RD_LAT-1:0]        rd_pipe;
  logic                       ret_vld;
  logic                       last_issue;
  logic                       last_ret;
  logic                       start_load;
  logic   [IDX_W-1:0]         wr_base;
  logic signed [ENTRY_W-1:0]  tbl [TABLE_DEPTH];

  logic                       inject;
  logic signed [DATA_W-1:0]   in_p0  [NUM_CH];
  logic signed [DATA_W-1:0]   out_p1 [NUM_CH];
  logic                       vld_p1;
  logic   [15:0]              lfsr   [NUM_CH];

  function automatic logic signed [DATA_W-1:0] sat_add(
    input logic signed [DATA_W-1:0]  a,
    input logic signed [ENTRY_W-1:0] b
  );
    logic signed [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {{(DATA_W + 1 - ENTRY_W){b[ENTRY_W-1]}}, b};
    if (sum[DATA_W] != sum[DATA_W-1])
      sat_add = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_add = sum[DATA_W-1:0];
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign mem_rd     = (state == FETCH);
  assign mem_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(issue_cnt);
  assign done_wait  = (state == READY);
  assign last_issue = (issue_cnt == CNT_W'(WORDS - 1));
  assign last_ret   = (ret_cnt == CNT_W'(WORDS - 1));
  assign start_load = load_mem && (state == IDLE || state == READY);
  // Returns landing outside a load (e.g. after an abort) are never written.
  assign ret_vld    = rd_pipe[RD_LAT-1] && (state == FETCH || state == DRAIN);
  assign wr_base    = IDX_W'(ret_cnt) * IDX_W'(LANES);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_mem) state_nxt = FETCH;
      FETCH:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (ret_vld && last_ret) state_nxt = READY;
      READY:   if (load_mem) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      rd_pipe   <= '0;
    end else begin
      state      <= state_nxt;
      rd_pipe[0] <= mem_rd;
      for (int i = 1; i < RD_LAT; i++)
        rd_pipe[i] <= rd_pipe[i-1];
      if (start_load) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (state == FETCH && !last_issue)
          issue_cnt <= issue_cnt + CNT_W'(1);
        if (ret_vld)
          ret_cnt <= ret_cnt + CNT_W'(1);
      end
    end
  end

  // Table storage is data only; a return coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rstn && ret_vld) begin
      for (int j = 0; j < LANES; j++)
        tbl[wr_base + IDX_W'(j)] <= mem_rdata[j*ENTRY_W +: ENTRY_W];
    end
  end

  // p0: unpack incoming samples
  assign inject = en && done_wait;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign in_p0[g]                       = noise_in[g*DATA_W +: DATA_W];
    assign noise_out[g*DATA_W +: DATA_W]  = out_p1[g];
  end

  // p1: noise add with saturation, LFSR advance on consumed samples
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        out_p1[ch] <= '0;
        lfsr[ch]   <= SEED + 16'(ch);
      end
    end else begin
      vld_p1 <= noise_in_valid;
      if (noise_in_valid) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          out_p1[ch] <= inject ? sat_add(in_p0[ch], tbl[lfsr[ch][IDX_W-1:0]]) : in_p0[ch];
          if (inject)
            lfsr[ch] <= lfsr_step(lfsr[ch]);
        end
      end
    end
  end

  assign noise_out_valid = vld_p1;

endmodule

// File: tb/tb_noise_cdf_injector.sv
// Directed bench for noise_cdf_injector: one DUT with RD_LAT=1, one with RD_LAT=3.
module tb_noise_cdf_injector;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        load1 = 1'b0;
  logic        load3 = 1'b0;
  logic [13:0] addr1, addr3;
  logic        rd1, rd3;
  logic [63:0] rdata1, r3a, r3b, r3c;
  logic        dw1, dw3;
  logic [15:0] nin = 16'h0;
  logic        nin_v = 1'b0;
  logic [15:0] nout1, nout3;
  logic        nov1, nov3;
  logic        en3 = 1'b0;
  logic [15:0] nin3 = 16'h0;
  logic        nin3_v = 1'b0;
  logic [63:0] img [32];
  logic [63:0] old_img [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  noise_cdf_injector #(.BASE_ADDR(100), .RD_LAT(1)) dut (
    .clk(clk), .rstn(rstn), .en(en), .load_mem(load1),
    .mem_addr(addr1), .mem_rd(rd1), .mem_rdata(rdata1), .done_wait(dw1),
    .noise_in(nin), .noise_in_valid(nin_v),
    .noise_out(nout1), .noise_out_valid(nov1)
  );

  noise_cdf_injector #(.BASE_ADDR(2000), .RD_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .en(en3), .load_mem(load3),
    .mem_addr(addr3), .mem_rd(rd3), .mem_rdata(r3c), .done_wait(dw3),
    .noise_in(nin3), .noise_in_valid(nin3_v),
    .noise_out(nout3), .noise_out_valid(nov3)
  );

  // Memory models: one- and three-cycle read pipelines over the shared image
  always @(posedge clk) begin
    rdata1 <= rd1 ? img[5'(addr1 - 14'd100)] : 64'hDEAD_BEEF_DEAD_BEEF;
    r3a    <= rd3 ? img[5'(addr3 - 14'd2000)] : 64'hDEAD_BEEF_DEAD_BEEF;
    r3b    <= r3a;
    r3c    <= r3b;
  end

  function automatic logic [15:0] model_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic pulse_load(input bit sel);
    @(posedge clk); #1;
    if (sel) load3 = 1'b1; else load1 = 1'b1;
    @(posedge clk); #1;
    load1 = 1'b0;
    load3 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ((sel ? dw3 : dw1) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic apply(input logic [15:0] din);
    nin   = din;
    nin_v = 1'b1;
    @(posedge clk); #1;
    nin_v = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rd1 !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rd: got %b want 0", rd1); end
    n_cmp++; if (addr1 !== 14'd100) begin n_bad++; $display("FAIL reset_mem_addr: got %0d want 100", addr1); end
    n_cmp++; if (dw1 !== 1'b0) begin n_bad++; $display("FAIL reset_done_wait: got %b want 0", dw1); end
    n_cmp++; if (nout1 !== 16'h0000) begin n_bad++; $display("FAIL reset_noise_out: got %h want 0000", nout1); end
    n_cmp++; if (nov1 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", nov1); end
    n_cmp++; if (dut.lfsr[0] !== 16'hACE1) begin n_bad++; $display("FAIL reset_lfsr0: got %h want ace1", dut.lfsr[0]); end
    n_cmp++; if (dut.lfsr[1] !== 16'hACE2) begin n_bad++; $display("FAIL reset_lfsr1: got %h want ace2", dut.lfsr[1]); end
    n_cmp++; if (rd3 !== 1'b0 || addr3 !== 14'd2000) begin n_bad++; $display("FAIL reset_dut3_mem: got rd=%b addr=%0d want rd=0 addr=2000", rd3, addr3); end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rd1 !== 1'b0 || dw1 !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: got rd=%b dw=%b want 0 0", rd1, dw1); end
  endtask

  task automatic test_pass_through();
    en = 1'b1;
    apply({8'hF9, 8'h05});
    n_cmp++; if (nout1 !== 16'hF905) begin n_bad++; $display("FAIL pass_data: got %h want f905", nout1); end
    n_cmp++; if (nov1 !== 1'b1) begin n_bad++; $display("FAIL pass_valid: got %b want 1", nov1); end
    n_cmp++; if (dut.lfsr[0] !== 16'hACE1 || dut.lfsr[1] !== 16'hACE2) begin
      n_bad++; $display("FAIL pass_lfsr_hold: got %h %h want ace1 ace2", dut.lfsr[0], dut.lfsr[1]);
    end
    @(posedge clk); #1;
    n_cmp++; if (nov1 !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", nov1); end
    n_cmp++; if (nout1 !== 16'hF905) begin n_bad++; $display("FAIL idle_hold: got %h want f905", nout1); end
    en = 1'b0;
  endtask

  task automatic test_load_basic();
    int rd_cnt, addr_bad, last_rd, rise, tb_bad;
    logic [7:0] e;
    for (int k = 0; k < 32; k++) img[k] = {$urandom(), $urandom()};
    pulse_load(1'b0);
    rd_cnt = 0; addr_bad = 0; last_rd = -100; rise = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rd1) begin
        if (addr1 !== 14'(100 + rd_cnt)) addr_bad++;
        rd_cnt++;
        last_rd = c;
      end
      if (dw1) begin
        rise = c;
        break;
      end
    end
    n_cmp++; if (rise < 0) begin n_bad++; $display("FAIL basic_done_timeout: got no done_wait want rise"); end
    n_cmp++; if (rd_cnt !== 32) begin n_bad++; $display("FAIL basic_rd_count: got %0d want 32", rd_cnt); end
    n_cmp++; if (addr_bad !== 0) begin n_bad++; $display("FAIL basic_addr_seq: got %0d bad addresses want 0", addr_bad); end
    n_cmp++; if (rise - last_rd !== 2) begin n_bad++; $display("FAIL basic_done_latency: got %0d want 2", rise - last_rd); end
    tb_bad = 0;
    for (int i = 0; i < 256; i++) begin
      e = img[i/8][(i%8)*8 +: 8];
      if (dut.tbl[i] !== e) tb_bad++;
    end
    n_cmp++; if (tb_bad !== 0) begin n_bad++; $display("FAIL basic_table: got %0d wrong entries want 0", tb_bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_const_table();
    bit ok;
    for (int k = 0; k < 32; k++) img[k] = {8{8'h03}};
    pulse_load(1'b0);
    wait_done(1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL const3_load: got timeout want done_wait"); end
    en = 1'b1;
    apply({8'h14, 8'h0A});
    n_cmp++; if (nout1 !== 16'h170D) begin n_bad++; $display("FAIL const3_add: got %h want 170d", nout1); end
    apply({8'h80, 8'h7E});
    n_cmp++; if (nout1 !== 16'h837F) begin n_bad++; $display("FAIL const3_sat_hi: got %h want 837f", nout1); end
    en = 1'b0;
    apply({8'h22, 8'h11});
    n_cmp++; if (nout1 !== 16'h2211) begin n_bad++; $display("FAIL const3_en_off: got %h want 2211", nout1); end
    for (int k = 0; k < 32; k++) img[k] = {8{8'h80}};
    pulse_load(1'b0);
    wait_done(1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL constm128_load: got timeout want done_wait"); end
    en = 1'b1;
    apply({8'h64, 8'hFB});
    n_cmp++; if (nout1 !== 16'hE480) begin n_bad++; $display("FAIL constm128_sat_lo: got %h want e480", nout1); end
    en = 1'b0;
  endtask

  task automatic test_lfsr_index();
    bit ok;
    logic [15:0] m0, m1;
    logic [7:0]  e0, e1;
    int diff;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 32; k++)
      for (int j = 0; j < 8; j++)
        img[k][j*8 +: 8] = 8'(k*8 + j);
    pulse_load(1'b0);
    wait_done(1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL idx_load: got timeout want done_wait"); end
    en = 1'b1;
    m0 = 16'hACE1; m1 = 16'hACE2; e0 = 8'h0; e1 = 8'h0; diff = 0;
    for (int n = 0; n <= 1000; n++) begin
      @(posedge clk); #1;
      if (n > 0) begin
        n_cmp++; if (nout1[7:0] !== e0) begin n_bad++; $display("FAIL idx_ch0 sample %0d: got %h want %h", n-1, nout1[7:0], e0); end
        n_cmp++; if (nout1[15:8] !== e1) begin n_bad++; $display("FAIL idx_ch1 sample %0d: got %h want %h", n-1, nout1[15:8], e1); end
        if (nout1[7:0] != nout1[15:8]) diff++;
      end
      if (n < 1000) begin
        nin = 16'h0000; nin_v = 1'b1;
        e0 = m0[7:0]; e1 = m1[7:0];
        m0 = model_step(m0); m1 = model_step(m1);
      end else begin
        nin_v = 1'b0;
      end
    end
    n_cmp++; if (diff == 0) begin n_bad++; $display("FAIL idx_channels_differ: got %0d differing samples want >0", diff); end
    n_cmp++; if (dut.lfsr[0] !== m0 || dut.lfsr[1] !== m1) begin
      n_bad++; $display("FAIL idx_lfsr_final: got %h %h want %h %h", dut.lfsr[0], dut.lfsr[1], m0, m1);
    end
    en = 1'b0;
  endtask

  task automatic test_reload();
    bit ok;
    for (int k = 0; k < 32; k++) img[k] = {8{8'h01}};
    en = 1'b1;
    pulse_load(1'b0);
    n_cmp++; if (dw1 !== 1'b0) begin n_bad++; $display("FAIL reload_done_drop: got %b want 0", dw1); end
    apply({8'h22, 8'h11});
    n_cmp++; if (nout1 !== 16'h2211) begin n_bad++; $display("FAIL reload_pass_a: got %h want 2211", nout1); end
    apply({8'hC3, 8'h7F});
    n_cmp++; if (nout1 !== 16'hC37F) begin n_bad++; $display("FAIL reload_pass_b: got %h want c37f", nout1); end
    wait_done(1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL reload_done: got timeout want done_wait"); end
    apply(16'h0000);
    n_cmp++; if (nout1 !== 16'h0101) begin n_bad++; $display("FAIL reload_new_table: got %h want 0101", nout1); end
    apply({8'h7F, 8'h10});
    n_cmp++; if (nout1 !== 16'h7F11) begin n_bad++; $display("FAIL reload_sat: got %h want 7f11", nout1); end
    en = 1'b0;
  endtask

  task automatic test_latency_sweep();
    int rd_cnt, addr_bad, last_rd, rise, tb_bad;
    logic [7:0] e;
    for (int k = 0; k < 32; k++) img[k] = {$urandom(), $urandom()};
    pulse_load(1'b1);
    rd_cnt = 0; addr_bad = 0; last_rd = -100; rise = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rd3) begin
        if (addr3 !== 14'(2000 + rd_cnt)) addr_bad++;
        rd_cnt++;
        last_rd = c;
      end
      if (dw3) begin
        rise = c;
        break;
      end
    end
    n_cmp++; if (rise < 0) begin n_bad++; $display("FAIL lat3_done_timeout: got no done_wait want rise"); end
    n_cmp++; if (rd_cnt !== 32) begin n_bad++; $display("FAIL lat3_rd_count: got %0d want 32", rd_cnt); end
    n_cmp++; if (addr_bad !== 0) begin n_bad++; $display("FAIL lat3_addr_seq: got %0d bad addresses want 0", addr_bad); end
    n_cmp++; if (rise - last_rd !== 4) begin n_bad++; $display("FAIL lat3_done_latency: got %0d want 4", rise - last_rd); end
    tb_bad = 0;
    for (int i = 0; i < 256; i++) begin
      e = img[i/8][(i%8)*8 +: 8];
      if (dut3.tbl[i] !== e) tb_bad++;
    end
    n_cmp++; if (tb_bad !== 0) begin n_bad++; $display("FAIL lat3_table: got %0d wrong entries want 0", tb_bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fetch();
    int tb_bad;
    logic [7:0] e;
    for (int k = 0; k < 32; k++) begin
      old_img[k] = img[k];
      img[k]     = img[k] ^ 64'hFFFF_FFFF_FFFF_FFFF;
    end
    pulse_load(1'b1);
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    n_cmp++; if (rd3 !== 1'b0) begin n_bad++; $display("FAIL abort_mem_rd: got %b want 0", rd3); end
    n_cmp++; if (dw3 !== 1'b0 || addr3 !== 14'd2000) begin n_bad++; $display("FAIL abort_idle: got dw=%b addr=%0d want 0 2000", dw3, addr3); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (rd3 !== 1'b0 || dw3 !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: got rd=%b dw=%b want 0 0", rd3, dw3); end
    tb_bad = 0;
    for (int i = 0; i < 256; i++) begin
      e = (i/8 < 2) ? img[i/8][(i%8)*8 +: 8] : old_img[i/8][(i%8)*8 +: 8];
      if (dut3.tbl[i] !== e) tb_bad++;
    end
    n_cmp++; if (tb_bad !== 0) begin n_bad++; $display("FAIL abort_late_returns: got %0d wrong entries want 0", tb_bad); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 32; k++) begin
      img[k]     = 64'h0;
      old_img[k] = 64'h0;
    end
    test_reset();
    test_pass_through();
    test_load_basic();
    test_const_table();
    test_lfsr_index();
    test_reload();
    test_latency_sweep();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
